// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Unified instruction/data memory slave for a multicycle CPU.
//             Accepts a read or write request while idle, waits a configurable
//             number of cycles, performs the access, then pulses mem_ready for
//             one cycle. Misaligned requests and requests with both MemRead and
//             MemWrite high are not performed. They complete immediately with
//             mem_err pulsed alongside mem_ready.
//  Ports    : clk        - system clock, rising edge
//             rst        - asynchronous, active-high reset
//             MemRead    - read request (level, sampled only while idle)
//             MemWrite   - write request (level, sampled only while idle)
//             addr       - byte address, word index taken from addr[IDX+1:2]
//             wdata      - write data
//             rdata      - registered read data, held until the next read
//             mem_ready  - one-cycle completion pulse
//             mem_busy   - high whenever the responder is not idle
//             mem_err    - one-cycle pulse with mem_ready on an illegal request
//  Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int READ_LAT    = 2,
    parameter int WRITE_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        mem_err
);

    localparam int c_IDX_W   = $clog2(DEPTH_WORDS);
    localparam int c_LAT_MAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    // The counter only ever holds LAT-1, so clog2(max LAT) bits suffice.
    localparam int c_CNT_W   = (c_LAT_MAX > 1) ? $clog2(c_LAT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_RD_LOAD = c_CNT_W'(READ_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LOAD = c_CNT_W'(WRITE_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_op_wr;
    logic [c_IDX_W-1:0]   r_idx;
    logic [31:0]          r_wdata;
    logic [31:0]          r_rdata;
    logic                 r_mem_ready;
    logic                 r_mem_err;

    // Storage is deliberately outside the reset domain: reset never clears it.
    logic [31:0]          r_mem [DEPTH_WORDS];

    logic                 w_req_any;
    logic                 w_illegal;
    logic                 w_mem_we;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_unused_addr;

    assign w_req_any = MemRead | MemWrite;
    assign w_illegal = (MemRead & MemWrite) | (addr[1:0] != 2'b00);
    assign w_idx     = addr[c_IDX_W+1:2];

    // Upper address bits are ignored so addresses wrap modulo the array size.
    assign w_unused_addr = ^{addr[31:c_IDX_W+2]};

    // The write fires on the last WAIT cycle. An asynchronous reset forces the
    // state to IDLE first, so an aborted write never reaches the array.
    assign w_mem_we = (r_state == S_WAIT) && (r_cnt == '0) && r_op_wr;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op_wr     <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_mem_ready <= 1'b0;
            r_mem_err   <= 1'b0;
        end else begin
            // Completion flags are pulses: cleared unless set below.
            r_mem_ready <= 1'b0;
            r_mem_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        if (w_illegal) begin
                            // Respond straight away without touching the array.
                            r_state     <= S_RESP;
                            r_mem_ready <= 1'b1;
                            r_mem_err   <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                            r_op_wr <= MemWrite;
                            r_idx   <= w_idx;
                            r_wdata <= wdata;
                            r_cnt   <= MemWrite ? c_WR_LOAD : c_RD_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end else begin
                        if (!r_op_wr) begin
                            r_rdata <= r_mem[r_idx];
                        end
                        r_state     <= S_RESP;
                        r_mem_ready <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata     = r_rdata;
    assign mem_ready = r_mem_ready;
    assign mem_err   = r_mem_err;
    assign mem_busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Scoreboard testbench for mem_responder. The driver pushes the
//             expected completion of each request into a queue; a monitor pops
//             and compares whenever mem_ready is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int c_DEPTH = 256;
    localparam int c_RLAT  = 4;
    localparam int c_WLAT  = 3;

    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mem_ready;
    logic        mem_busy;
    logic        mem_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;   // -1: latency not checked
        int          acc;   // cycle number of the acceptance edge
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] cur_rdata;

    mem_responder #(
        .DEPTH_WORDS (c_DEPTH),
        .READ_LAT    (c_RLAT),
        .WRITE_LAT   (c_WLAT)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .mem_ready (mem_ready),
        .mem_busy  (mem_busy),
        .mem_err   (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares every completion against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_ready", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        chk("rdata", rdata, e.rdata);
                        chk("mem_err", {31'd0, mem_err}, {31'd0, e.err});
                        if (e.lat >= 0) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    end
                end else begin
                    chk("err_without_ready", {31'd0, mem_err}, 32'd0);
                end
            end
        end
    end

    // Issue one request, push its expectation, wait for completion and check
    // rdata stability, busy duration and return to idle.
    task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rd_exp,
                       input logic is_err);
        exp_t        e;
        int          busy;
        bit          seen;
        logic [31:0] prev;
        busy = 0;
        seen = 0;
        prev = cur_rdata;
        @(negedge clk);
        MemRead  = rd;
        MemWrite = wr;
        addr     = a;
        wdata    = d;
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        if (rd && !is_err) cur_rdata = rd_exp;
        e.rdata = cur_rdata;
        e.err   = is_err;
        e.lat   = is_err ? -1 : (rd ? c_RLAT : c_WLAT);
        e.acc   = cyc;
        sb.push_back(e);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_busy) busy++;
            if (mem_ready) begin
                seen = 1;
                break;
            end
            chk("rdata_hold", rdata, prev);
        end
        if (!seen) begin
            chk("ready_timeout", 32'd0, 32'd1);
        end else begin
            if (!is_err) chk("busy_cycles", 32'(busy), 32'(e.lat + 1));
            @(negedge clk);
            chk("idle_after", {30'd0, mem_busy, mem_ready}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        exp_t e;
        rst       = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        addr      = '0;
        wdata     = '0;
        cur_rdata = '0;
        #12;
        chk("reset_outputs", {rdata[28:0], mem_ready, mem_busy, mem_err}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic write then read.
        req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        req(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Read with the long latency: five busy cycles, rdata held until done.
        req(1'b0, 1'b1, 32'h04, 32'h12345678, 32'h0, 1'b0);
        req(1'b1, 1'b0, 32'h04, 32'h0, 32'h12345678, 1'b0);

        // Illegal requests leave the array and rdata alone.
        req(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
        req(1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
        req(1'b1, 1'b1, 32'h20, 32'h99999999, 32'h0, 1'b1);
        req(1'b0, 1'b1, 32'h22, 32'h77777777, 32'h0, 1'b1);
        req(1'b1, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

        // Address wrap modulo DEPTH_WORDS*4, at both ends of the array.
        req(1'b0, 1'b1, 32'h000, 32'hA5A5A5A5, 32'h0, 1'b0);
        req(1'b1, 1'b0, 32'h400, 32'h0, 32'hA5A5A5A5, 1'b0);
        req(1'b0, 1'b1, 32'h7FC, 32'h0F0F0F0F, 32'h0, 1'b0);
        req(1'b1, 1'b0, 32'h3FC, 32'h0, 32'h0F0F0F0F, 1'b0);

        // Held MemRead: re-accepted on the first IDLE cycle after RESP, with
        // the address present at each acceptance edge.
        req(1'b0, 1'b1, 32'h30, 32'h33333333, 32'h0, 1'b0);
        req(1'b0, 1'b1, 32'h40, 32'h44444444, 32'h0, 1'b0);
        @(negedge clk);
        MemRead = 1'b1;
        addr    = 32'h30;
        @(posedge clk);
        #1;
        e.rdata = 32'h33333333; e.err = 1'b0; e.lat = c_RLAT; e.acc = cyc;
        sb.push_back(e);
        e.rdata = 32'h44444444; e.err = 1'b0; e.lat = c_RLAT;
        e.acc   = cyc + c_RLAT + 2;
        sb.push_back(e);
        cnt = 0;
        for (int i = 0; i < 60 && cnt < 2; i++) begin
            @(negedge clk);
            if (mem_ready) cnt++;
            if (i == 0) addr = 32'h40;
        end
        MemRead = 1'b0;
        cur_rdata = 32'h44444444;
        chk("held_pulses", 32'(cnt), 32'd2);
        @(negedge clk);
        @(negedge clk);

        // Reset in the middle of a write aborts it.
        req(1'b0, 1'b1, 32'h08, 32'h22222222, 32'h0, 1'b0);
        req(1'b1, 1'b0, 32'h08, 32'h0, 32'h22222222, 1'b0);
        @(negedge clk);
        MemWrite = 1'b1;
        addr     = 32'h08;
        wdata    = 32'h11111111;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_flags", {29'd0, mem_ready, mem_busy, mem_err}, 32'd0);
        cur_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        req(1'b1, 1'b0, 32'h08, 32'h0, 32'h22222222, 1'b0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
